sd_spi_master: RTL

Parametrised SPI mode-0 byte engine for SD cards with two selectable SPI clock rates, an init-clock generator, multi-byte chip-select hold and an optional running CRC16 on received data. It sits between the SD command/read sequencer and the card pins. It replaces the fixed-divide single-byte controller and samples MISO on the rising SPI edge.

---
 rtl/sd_spi_master.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/sd_spi_master.sv
// SPI mode-0 byte engine for SD cards: slow/fast clock, init clocks, CS hold.
// Define SD_SPI_CRC16_EN to build the running CRC16 (CCITT 0x1021) on received bytes.
module sd_spi_master #(
   parameter int CLK_DIV_SLOW = 34,
   parameter int CLK_DIV_FAST = 1,
   parameter int INIT_CLOCKS  = 80
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        init_start,
   output logic        init_done,
   input  logic        xfer_start,
   input  logic [7:0]  tx_byte,
   input  logic        speed_fast,
   input  logic        cs_hold,
   output logic        xfer_ready,
   output logic [7:0]  rx_byte,
   output logic        rx_valid,
   input  logic        crc_clear,
   output logic [15:0] crc16,
   output logic        spi_clk,
   output logic        spi_mosi,
   input  logic        spi_miso,
   output logic        spi_cs_n
);

   localparam logic [7:0] DIV_SLOW  = 8'(CLK_DIV_SLOW);
   localparam logic [7:0] DIV_FAST  = 8'(CLK_DIV_FAST);
   localparam logic [7:0] INIT_LAST = 8'(INIT_CLOCKS - 1);

   typedef enum logic [1:0] {IDLE, INIT, SHIFT} state_t;

   state_t     state;
   logic [7:0] div_l;
   logic [7:0] div_cnt;
   logic [7:0] bit_cnt;
   logic [7:0] init_cnt;
   logic [6:0] tx_sh;
   logic [7:0] rx_sh;
   logic       cs_hold_l;
   logic       half_end;

   assign half_end = (div_cnt == div_l - 8'd1);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         div_l      <= DIV_SLOW;
         div_cnt    <= 8'd0;
         bit_cnt    <= 8'd0;
         init_cnt   <= 8'd0;
         tx_sh      <= 7'd0;
         rx_sh      <= 8'd0;
         cs_hold_l  <= 1'b0;
         xfer_ready <= 1'b1;
         rx_byte    <= 8'd0;
         rx_valid   <= 1'b0;
         init_done  <= 1'b0;
         spi_clk    <= 1'b0;
         spi_mosi   <= 1'b1;
         spi_cs_n   <= 1'b1;
      end else begin
         rx_valid  <= 1'b0;
         init_done <= 1'b0;
         case (state)
            IDLE: begin
               // init_start takes priority over a same-cycle xfer_start
               if (init_start) begin
                  state      <= INIT;
                  xfer_ready <= 1'b0;
                  div_l      <= DIV_SLOW;
                  div_cnt    <= 8'd0;
                  init_cnt   <= 8'd0;
                  spi_cs_n   <= 1'b1;
                  spi_mosi   <= 1'b1;
               end else if (xfer_start) begin
                  state      <= SHIFT;
                  xfer_ready <= 1'b0;
                  div_l      <= speed_fast ? DIV_FAST : DIV_SLOW;
                  div_cnt    <= 8'd0;
                  bit_cnt    <= 8'd0;
                  tx_sh      <= tx_byte[6:0];
                  cs_hold_l  <= cs_hold;
                  spi_cs_n   <= 1'b0;
                  spi_mosi   <= tx_byte[7];
               end
            end
            INIT: begin
               if (half_end) begin
                  div_cnt <= 8'd0;
                  spi_clk <= ~spi_clk;
                  if (spi_clk) begin
                     if (init_cnt == INIT_LAST) begin
                        state      <= IDLE;
                        xfer_ready <= 1'b1;
                        init_done  <= 1'b1;
                     end else begin
                        init_cnt <= init_cnt + 8'd1;
                     end
                  end
               end else begin
                  div_cnt <= div_cnt + 8'd1;
               end
            end
            SHIFT: begin
               // MISO is captured on the rising SPI edge, MOSI advances on the falling edge
               if (half_end) begin
                  div_cnt <= 8'd0;
                  if (!spi_clk) begin
                     spi_clk <= 1'b1;
                     rx_sh   <= {rx_sh[6:0], spi_miso};
                  end else begin
                     spi_clk <= 1'b0;
                     if (bit_cnt == 8'd7) begin
                        state      <= IDLE;
                        xfer_ready <= 1'b1;
                        rx_byte    <= rx_sh;
                        rx_valid   <= 1'b1;
                        spi_mosi   <= 1'b1;
                        spi_cs_n   <= ~cs_hold_l;
                     end else begin
                        bit_cnt  <= bit_cnt + 8'd1;
                        spi_mosi <= tx_sh[6];
                        tx_sh    <= {tx_sh[5:0], 1'b0};
                     end
                  end
               end else begin
                  div_cnt <= div_cnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SD_SPI_CRC16_EN
   logic [15:0] crc_q;

   function automatic logic [15:0] crc_byte(input logic [15:0] c_in, input logic [7:0] d);
      logic [15:0] c;
      c = c_in;
      for (int i = 7; i >= 0; i--) begin
         if (c[15] ^ d[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
         else              c = {c[14:0], 1'b0};
      end
      return c;
   endfunction

   // A clear coinciding with a new byte restarts the CRC from that byte
   always_ff @(posedge clk) begin
      if (reset)          crc_q <= 16'h0000;
      else if (rx_valid)  crc_q <= crc_byte(crc_clear ? 16'h0000 : crc_q, rx_byte);
      else if (crc_clear) crc_q <= 16'h0000;
   end

   assign crc16 = crc_q;
`else
   logic unused_crc_clear;
   assign unused_crc_clear = crc_clear;
   assign crc16 = 16'h0000;
`endif

endmodule
